ddr_wcamerafifo: RTL
====================

DDR_WCAMERAFIFO -- requirements
Module: ddr_wcamerafifo

Interface
REQ-001 SHALL have parameter MAXADDR, default 18'd245_760, meaning the 32-bit word count of one frame per bank.
REQ-002 SHALL have parameter BURST_LEN, default 10'd256, meaning the words per DDR write burst.
REQ-003 SHALL use one clock and an asynchronous, active-high reset:
- ddr_clk  in  1  sole clock
- ddr_rst  in  1  asynchronous, active-high reset
REQ-004 SHALL have the following camera-side ports:
- camera_vsync  in  1  frame sync from the camera domain, active-high
- r_fifo_len  in  10  camera FIFO read-side word count
- r_fifo_empty  in  1  camera FIFO empty
- r_fifo_rd_en  out  1  camera FIFO read strobe
- r_fifo_data  in  32  camera FIFO read data
REQ-005 SHALL have the following DDR write-controller ports:
- ddr_ready  in  1  DDR initialised
- mem_wen  out  1  write request
- mem_wen_valid  in  1  request accepted, 1-cycle pulse
- wr_addr  out  25  burst start address
- wr_len  out  10  burst length
- wr_burst_data_req  in  1  controller wants a word
- wr_burst_data  out  32  write data
- wr_burst_finish  in  1  burst done, 1-cycle pulse
REQ-006 SHALL have the following control ports:
- wr_channal  in  4  channel field of the address
- frame_wr_done  out  1  1-cycle pulse when a frame is complete
- slave_sel_rd_load  out  1  1-cycle pulse to load the read bank
- slave_sel_rd_bank  out  2  bank holding the newest complete frame

Function
REQ-007 SHALL drive wr_addr = {wr_bank[1:0], 1'b0, wr_channal, wr_offset[17:0]}.
REQ-008 SHALL hold wr_len constant at BURST_LEN.
REQ-009 SHALL synchronise camera_vsync through two flops; vs_pos is the rising edge of the synchronised signal.
REQ-010 SHALL implement states IDLE, WAIT_DATA, REQ, BURST, DONE.
REQ-011 IDLE -> WAIT_DATA on vs_pos while ddr_ready=1; wr_offset SHALL be cleared to 0 on this transition.
REQ-012 WAIT_DATA -> REQ when r_fifo_len >= BURST_LEN and r_fifo_empty=0; mem_wen SHALL go high on the following cycle.
REQ-013 In REQ, mem_wen SHALL stay high until mem_wen_valid and drop in the cycle after it; on that cycle the state moves to BURST.
REQ-014 In BURST, r_fifo_rd_en SHALL equal wr_burst_data_req combinationally, and wr_burst_data SHALL equal r_fifo_data (show-ahead FIFO, zero latency).
REQ-015 On wr_burst_finish, wr_offset SHALL increase by BURST_LEN; if the new value equals MAXADDR -> DONE, otherwise -> WAIT_DATA.
REQ-016 DONE SHALL last exactly 1 cycle and do all of the following:
- pulse frame_wr_done and slave_sel_rd_load
- set slave_sel_rd_bank to wr_bank
- set wr_bank to wr_bank+1 (mod 4)
- go to IDLE
REQ-017 On vs_pos in WAIT_DATA (frame incomplete), the partial frame SHALL be dropped: wr_offset cleared to 0, wr_bank unchanged, no done pulse, state stays WAIT_DATA.
REQ-018 On vs_pos in REQ or BURST, the event SHALL be latched and applied as in REQ-017 when the burst ends; the burst itself SHALL never be truncated.
REQ-019 On vs_pos coinciding with DONE, the block SHALL first complete DONE, then take the IDLE -> WAIT_DATA transition on the next cycle using the latched edge.
REQ-020 If ddr_ready drops, no new mem_wen SHALL be raised; an in-flight REQ or BURST SHALL complete.
REQ-021 r_fifo_rd_en SHALL be 0 in every state except BURST.

Reset
REQ-022 While ddr_rst=1, the block SHALL hold:
- state = IDLE
- mem_wen = 0, r_fifo_rd_en = 0, frame_wr_done = 0, slave_sel_rd_load = 0
- slave_sel_rd_bank = 0, wr_bank = 0, wr_offset = 0
- vsync synchroniser flops and the latched-edge flag = 0
REQ-023 Reset asserted mid-burst SHALL abort immediately; a following frame SHALL start from offset 0, bank 0.

Structure
REQ-024 Constants SHALL live in a shared ddr package: state encoding, BURST_LEN, MAXADDR, and the address field positions (bank [24:23], pad [22], channel [21:18], offset [17:0]).
REQ-025 The vsync edge synchroniser SHALL be one sub-module, sync_edge_det (2-flop plus rising-edge output).

Verification
REQ-026 Reset, ddr_ready=1, vsync pulse, FIFO kept at 300 words -> first mem_wen with wr_addr=0x0000000, wr_len=256; after 960 bursts, frame_wr_done pulses with slave_sel_rd_bank=0 and wr_bank=1.
REQ-027 Four consecutive full frames, wr_channal=4'h3 -> wr_addr bank field cycles 0,1,2,3,0; channel field stays 3; slave_sel_rd_bank tracks each completed bank.
REQ-028 r_fifo_len held at 255 -> no mem_wen; raise to 256 -> mem_wen within 2 cycles.
REQ-029 Vsync arrives mid-burst at offset 0x1000 -> burst completes with 256 rd_en strobes, next wr_addr offset = 0, bank unchanged, no frame_wr_done.
REQ-030 mem_wen_valid delayed 50 cycles -> mem_wen held high for all 50 cycles, exactly one burst issued, no FIFO reads before BURST.
REQ-031 Reset asserted during BURST -> all outputs return to reset values in the same cycle; next vsync restarts at wr_addr=0.

Source files
------------

// File: rtl/ddr_wcamerafifo_pkg.sv
// Shared constants for the DDR camera write path: FSM encoding, default
// frame/burst sizes and the write-address field layout.
package ddr_wcamerafifo_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_DATA,
      REQ,
      BURST,
      DONE
   } wr_state_e;

   localparam logic [17:0] MAXADDR_DEF   = 18'd245_760;
   localparam logic [9:0]  BURST_LEN_DEF = 10'd256;

   localparam int BANK_MSB = 24;
   localparam int BANK_LSB = 23;
   localparam int PAD_BIT  = 22;
   localparam int CH_MSB   = 21;
   localparam int CH_LSB   = 18;
   localparam int OFS_MSB  = 17;
   localparam int OFS_LSB  = 0;

   function automatic logic [24:0] pack_wr_addr(input logic [1:0]  bank,
                                                input logic [3:0]  ch,
                                                input logic [17:0] ofs);
      logic [24:0] a;
      a                   = '0;
      a[BANK_MSB:BANK_LSB] = bank;
      a[PAD_BIT]           = 1'b0;
      a[CH_MSB:CH_LSB]     = ch;
      a[OFS_MSB:OFS_LSB]   = ofs;
      return a;
   endfunction

endpackage

// File: rtl/ddr_wcamerafifo_sync_edge_det.sv
// Two-flop synchroniser for an asynchronous level, plus a one-cycle pulse on
// the rising edge of the synchronised signal.
module sync_edge_det
   import ddr_wcamerafifo_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic d_in,
   output logic rise
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = d_in;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/ddr_wcamerafifo.sv
// Moves camera frames from a show-ahead FIFO into DDR as fixed-length write
// bursts, rotating through four frame banks and announcing each finished bank.
module ddr_wcamerafifo
   import ddr_wcamerafifo_pkg::*;
#(
   parameter logic [17:0] MAXADDR   = MAXADDR_DEF,
   parameter logic [9:0]  BURST_LEN = BURST_LEN_DEF
) (
   input  logic        ddr_clk,
   input  logic        ddr_rst,
   input  logic        camera_vsync,
   input  logic [9:0]  r_fifo_len,
   input  logic        r_fifo_empty,
   output logic        r_fifo_rd_en,
   input  logic [31:0] r_fifo_data,
   input  logic        ddr_ready,
   output logic        mem_wen,
   input  logic        mem_wen_valid,
   output logic [24:0] wr_addr,
   output logic [9:0]  wr_len,
   input  logic        wr_burst_data_req,
   output logic [31:0] wr_burst_data,
   input  logic        wr_burst_finish,
   input  logic [3:0]  wr_channal,
   output logic        frame_wr_done,
   output logic        slave_sel_rd_load,
   output logic [1:0]  slave_sel_rd_bank
);

   wr_state_e   state_q, state_d;
   logic [17:0] wr_offset_q, wr_offset_d;
   logic [1:0]  wr_bank_q, wr_bank_d;
   logic [1:0]  rd_bank_q, rd_bank_d;
   logic        mem_wen_q, mem_wen_d;
   logic        vs_pend_q, vs_pend_d;
   logic        frame_done_q, frame_done_d;
   logic        rd_load_q, rd_load_d;
   logic [17:0] ofs_next;
   logic        vs_pos;

   sync_edge_det u_vs_sync (
      .clk  (ddr_clk),
      .rst  (ddr_rst),
      .d_in (camera_vsync),
      .rise (vs_pos)
   );

   always_comb begin
      state_d      = state_q;
      wr_offset_d  = wr_offset_q;
      wr_bank_d    = wr_bank_q;
      rd_bank_d    = rd_bank_q;
      mem_wen_d    = mem_wen_q;
      vs_pend_d    = vs_pend_q;
      frame_done_d = 1'b0;
      rd_load_d    = 1'b0;
      ofs_next     = wr_offset_q + {8'd0, BURST_LEN};

      case (state_q)
         IDLE: begin
            if ((vs_pos || vs_pend_q) && ddr_ready) begin
               state_d     = WAIT_DATA;
               wr_offset_d = '0;
               vs_pend_d   = 1'b0;
            end
         end
         WAIT_DATA: begin
            // A new frame edge here abandons the partial frame in the same bank.
            if (vs_pos) begin
               wr_offset_d = '0;
               vs_pend_d   = 1'b0;
            end else if (ddr_ready && (r_fifo_len >= BURST_LEN) && !r_fifo_empty) begin
               state_d   = REQ;
               mem_wen_d = 1'b1;
            end
         end
         REQ: begin
            if (vs_pos) vs_pend_d = 1'b1;
            if (mem_wen_valid) begin
               mem_wen_d = 1'b0;
               state_d   = BURST;
            end
         end
         BURST: begin
            if (vs_pos) vs_pend_d = 1'b1;
            if (wr_burst_finish) begin
               // A completed frame wins; any pending edge then restarts from IDLE.
               if (ofs_next == MAXADDR) begin
                  state_d      = DONE;
                  wr_offset_d  = ofs_next;
                  frame_done_d = 1'b1;
                  rd_load_d    = 1'b1;
                  rd_bank_d    = wr_bank_q;
                  wr_bank_d    = wr_bank_q + 2'd1;
               end else if (vs_pos || vs_pend_q) begin
                  state_d     = WAIT_DATA;
                  wr_offset_d = '0;
                  vs_pend_d   = 1'b0;
               end else begin
                  state_d     = WAIT_DATA;
                  wr_offset_d = ofs_next;
               end
            end
         end
         DONE: begin
            if (vs_pos) vs_pend_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ddr_clk or posedge ddr_rst) begin
      if (ddr_rst) begin
         state_q      <= IDLE;
         wr_offset_q  <= '0;
         wr_bank_q    <= '0;
         rd_bank_q    <= '0;
         mem_wen_q    <= 1'b0;
         vs_pend_q    <= 1'b0;
         frame_done_q <= 1'b0;
         rd_load_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_offset_q  <= wr_offset_d;
         wr_bank_q    <= wr_bank_d;
         rd_bank_q    <= rd_bank_d;
         mem_wen_q    <= mem_wen_d;
         vs_pend_q    <= vs_pend_d;
         frame_done_q <= frame_done_d;
         rd_load_q    <= rd_load_d;
      end
   end

   assign mem_wen           = mem_wen_q;
   assign r_fifo_rd_en      = (state_q == BURST) && wr_burst_data_req;
   assign wr_burst_data     = r_fifo_data;
   assign wr_len            = BURST_LEN;
   assign wr_addr           = pack_wr_addr(wr_bank_q, wr_channal, wr_offset_q);
   assign frame_wr_done     = frame_done_q;
   assign slave_sel_rd_load = rd_load_q;
   assign slave_sel_rd_bank = rd_bank_q;

endmodule
